// File: rtl/eeprom_pkg.sv
// eeprom_pkg
//   Definitions shared by the EEPROM programmer and the readback verifier:
//   the verifier state encoding and the default bus geometry / read timing.
package eeprom_pkg;

   localparam int EE_ADDR_W    = 13;  // EEPROM address width
   localparam int EE_DATA_W    = 8;   // EEPROM data width
   localparam int EE_READ_WAIT = 8;   // clk cycles OE held low before sampling

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP   = 3'd1,
      ST_WAIT    = 3'd2,
      ST_SAMPLE  = 3'd3,
      ST_RECOVER = 3'd4,
      ST_FINISH  = 3'd5
   } verify_state_e;

endpackage

// File: rtl/eeprom_readback_verify_if.sv
// eeprom_readback_verify_if
//   Bundles the expected-data stream (valid/ready) and the EEPROM read pins
//   seen by the readback verifier.
//   master : verifier side  (drives exp_ready, ee_addr, ee_oe_n)
//   slave  : environment side (drives exp_data, exp_valid, ee_data_in)
interface eeprom_readback_verify_if
   import eeprom_pkg::*;
#(
   parameter int ADDR_W = EE_ADDR_W,
   parameter int DATA_W = EE_DATA_W
);

   logic [DATA_W-1:0] exp_data;    // expected byte for the current address
   logic              exp_valid;   // exp_data valid
   logic              exp_ready;   // verifier takes exp_data this cycle
   logic [ADDR_W-1:0] ee_addr;     // EEPROM address
   logic              ee_oe_n;     // EEPROM output enable, active-low
   logic [DATA_W-1:0] ee_data_in;  // EEPROM data bus, read direction

   modport master (
      input  exp_data, exp_valid, ee_data_in,
      output exp_ready, ee_addr, ee_oe_n
   );

   modport slave (
      output exp_data, exp_valid, ee_data_in,
      input  exp_ready, ee_addr, ee_oe_n
   );

endinterface

// File: rtl/eeprom_readback_verify.sv
// eeprom_readback_verify
//   Reads the parallel EEPROM back byte by byte (addresses 0..LENGTH-1) once
//   the programmer has released the bus and compares each byte against an
//   expected-data stream. Reports pass/fail, a saturating mismatch count and
//   the first failing address.
// Ports
//   clk            clock
//   reset          synchronous, active-low
//   start          1-cycle pulse, begins a pass when idle (ignored while busy)
//   bus            expected stream + EEPROM read pins (master modport)
//   busy           pass in progress
//   done           1-cycle pulse at end of pass
//   pass           valid from done until next start: 1 = zero mismatches
//   err_count      mismatch count, saturating
//   first_err_addr address of first mismatch, 0 if none
// Build option
//   EEPROM_VERIFY_DUMP_EN: adds dump_data/dump_valid, presenting every byte
//   read at a handshake for one cycle (no backpressure).
module eeprom_readback_verify
   import eeprom_pkg::*;
#(
   parameter int ADDR_W    = EE_ADDR_W,
   parameter int DATA_W    = EE_DATA_W,
   parameter int LENGTH    = 64,
   parameter int READ_WAIT = EE_READ_WAIT,
   parameter int ERR_W     = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   eeprom_readback_verify_if.master bus,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ERR_W-1:0]  err_count,
   output logic [ADDR_W-1:0] first_err_addr
`ifdef EEPROM_VERIFY_DUMP_EN
   ,
   output logic [DATA_W-1:0] dump_data,
   output logic              dump_valid
`endif
);

   localparam int CNT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LENGTH - 1);
   localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(READ_WAIT - 1);

   verify_state_e     state_q;
   logic [ADDR_W-1:0] addr_q;
   logic              oe_n_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] rd_q;
   logic [DATA_W-1:0] exp_q;
   logic              busy_q;
   logic              done_q;
   logic              pass_q;
   logic [ERR_W-1:0]  err_q;
   logic [ADDR_W-1:0] first_q;
`ifdef EEPROM_VERIFY_DUMP_EN
   logic              dump_valid_q;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         oe_n_q  <= 1'b1;
         cnt_q   <= '0;
         rd_q    <= '0;
         exp_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         first_q <= '0;
`ifdef EEPROM_VERIFY_DUMP_EN
         dump_valid_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
`ifdef EEPROM_VERIFY_DUMP_EN
         dump_valid_q <= 1'b0;
`endif
         case (state_q)
            ST_IDLE: begin
               oe_n_q <= 1'b1;
               if (start) begin
                  err_q   <= '0;
                  first_q <= '0;
                  pass_q  <= 1'b0;
                  addr_q  <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               oe_n_q  <= 1'b0;
               cnt_q   <= '0;
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               if (cnt_q == WAIT_LAST) begin
                  state_q <= ST_SAMPLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_SAMPLE: begin
               // Both bytes are captured here and compared one cycle later,
               // so the EEPROM pins pass through exactly one flop.
               if (bus.exp_valid) begin
                  rd_q    <= bus.ee_data_in;
                  exp_q   <= bus.exp_data;
`ifdef EEPROM_VERIFY_DUMP_EN
                  dump_valid_q <= 1'b1;
`endif
                  state_q <= ST_RECOVER;
               end
            end
            ST_RECOVER: begin
               oe_n_q <= 1'b1;
               if (rd_q != exp_q) begin
                  if (err_q != '1) begin
                     err_q <= err_q + 1'b1;
                  end
                  // A saturating count never returns to zero, so zero means
                  // no mismatch seen yet in this pass.
                  if (err_q == '0) begin
                     first_q <= addr_q;
                  end
               end
               if (addr_q == LAST_ADDR) begin
                  state_q <= ST_FINISH;
               end else begin
                  addr_q  <= addr_q + 1'b1;
                  state_q <= ST_SETUP;
               end
            end
            ST_FINISH: begin
               done_q  <= 1'b1;
               pass_q  <= (err_q == '0);
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.exp_ready  = (state_q == ST_SAMPLE);
   assign bus.ee_addr    = addr_q;
   assign bus.ee_oe_n    = oe_n_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_count      = err_q;
   assign first_err_addr = first_q;

`ifdef EEPROM_VERIFY_DUMP_EN
   assign dump_data  = rd_q;
   assign dump_valid = dump_valid_q;
`endif

endmodule

// File: tb/tb_eeprom_readback_verify.sv
// tb_eeprom_readback_verify
//   Directed bench for eeprom_readback_verify. DUT A (ERR_W=8) covers the
//   clean pass, corrupted bytes, stream stall, mid-pass reset and start while
//   busy; DUT B (ERR_W=2) covers mismatch-count saturation. Each DUT reads a
//   behavioural EEPROM array; the expected stream indexes a shared table by
//   the bench's own handshake count.
module tb_eeprom_readback_verify;

   localparam int AW  = 13;
   localparam int DW  = 8;
   localparam int LEN = 64;
   localparam int RW  = 8;
   // start edge .. done observed at the following falling edge
   localparam int PASS_CYC = LEN * (RW + 3) + 2;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic start_a = 1'b0;
   logic start_b = 1'b0;
   logic hs_clr = 1'b0;

   always #5 clk = ~clk;

   eeprom_readback_verify_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
   eeprom_readback_verify_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

   logic          busy_a, done_a, pass_a;
   logic [7:0]    err_a;
   logic [AW-1:0] first_a;
   logic          busy_b, done_b, pass_b;
   logic [1:0]    err_b;
   logic [AW-1:0] first_b;
`ifdef EEPROM_VERIFY_DUMP_EN
   logic [DW-1:0] dump_data_a, dump_data_b;
   logic          dump_valid_a, dump_valid_b;
`endif

   eeprom_readback_verify #(
      .ADDR_W(AW), .DATA_W(DW), .LENGTH(LEN), .READ_WAIT(RW), .ERR_W(8)
   ) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .bus(bus_a.master),
      .busy(busy_a), .done(done_a), .pass(pass_a),
      .err_count(err_a), .first_err_addr(first_a)
`ifdef EEPROM_VERIFY_DUMP_EN
      , .dump_data(dump_data_a), .dump_valid(dump_valid_a)
`endif
   );

   eeprom_readback_verify #(
      .ADDR_W(AW), .DATA_W(DW), .LENGTH(LEN), .READ_WAIT(RW), .ERR_W(2)
   ) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .bus(bus_b.master),
      .busy(busy_b), .done(done_b), .pass(pass_b),
      .err_count(err_b), .first_err_addr(first_b)
`ifdef EEPROM_VERIFY_DUMP_EN
      , .dump_data(dump_data_b), .dump_valid(dump_valid_b)
`endif
   );

   logic [7:0] expmem [LEN];
   logic [7:0] mem_a  [LEN];
   logic [7:0] mem_b  [LEN];
   int hs_a = 0, hs_b = 0, cyc = 0, done_cnt_a = 0, max_addr_a = 0;
   int checks = 0, errors = 0, t0 = 0;

   // EEPROM model: real data only while OE is low, inverted garbage otherwise
   assign bus_a.exp_data   = expmem[hs_a[5:0]];
   assign bus_a.ee_data_in = bus_a.ee_oe_n ? ~mem_a[bus_a.ee_addr[5:0]]
                                           : mem_a[bus_a.ee_addr[5:0]];
   assign bus_b.exp_data   = expmem[hs_b[5:0]];
   assign bus_b.ee_data_in = bus_b.ee_oe_n ? ~mem_b[bus_b.ee_addr[5:0]]
                                           : mem_b[bus_b.ee_addr[5:0]];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (hs_clr) begin
         hs_a <= 0;
         hs_b <= 0;
      end else begin
         if (bus_a.exp_valid && bus_a.exp_ready) hs_a <= hs_a + 1;
         if (bus_b.exp_valid && bus_b.exp_ready) hs_b <= hs_b + 1;
      end
   end

   always @(negedge clk) begin
      if (hs_clr) done_cnt_a <= 0;
      else if (done_a) done_cnt_a <= done_cnt_a + 1;
      if (busy_a && int'(bus_a.ee_addr) > max_addr_a) max_addr_a <= int'(bus_a.ee_addr);
   end

`ifdef EEPROM_VERIFY_DUMP_EN
   logic [7:0] dump_exp = '0;
   int dump_cnt = 0, dump_bad = 0;
   always @(posedge clk)
      if (bus_a.exp_valid && bus_a.exp_ready) dump_exp <= mem_a[bus_a.ee_addr[5:0]];
   always @(negedge clk) begin
      if (hs_clr) begin
         dump_cnt <= 0;
         dump_bad <= 0;
      end else if (dump_valid_a) begin
         dump_cnt <= dump_cnt + 1;
         if (dump_data_a !== dump_exp) dump_bad <= dump_bad + 1;
      end
   end
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic start_pass_a();
      @(negedge clk) hs_clr = 1'b1;
      @(negedge clk) hs_clr = 1'b0;
      start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
      t0 = cyc;
   endtask

   task automatic wait_done_a(output int lat);
      lat = -1;
      for (int i = 0; i < 2000; i++) begin
         if (done_a) begin
            lat = cyc - t0 + 1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic wait_addr_a(input int a, input bit need_ready, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if (int'(bus_a.ee_addr) == a && (!need_ready || bus_a.exp_ready)) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      int lat;
      bit ok, stall_ok, no_done;

      for (int i = 0; i < LEN; i++) begin
         expmem[i] = 8'(i * 7 + 3);
         mem_a[i]  = 8'(i * 7 + 3);
         mem_b[i]  = ~(8'(i * 7 + 3));
      end
      bus_a.exp_valid = 1'b1;
      bus_b.exp_valid = 1'b1;

      // reset values
      repeat (3) @(negedge clk);
      check("rst_addr", 32'(bus_a.ee_addr), 0);
      check("rst_oe_n", 32'(bus_a.ee_oe_n), 1);
      check("rst_ready", 32'(bus_a.exp_ready), 0);
      check("rst_busy", 32'(busy_a), 0);
      check("rst_done", 32'(done_a), 0);
      check("rst_pass", 32'(pass_a), 0);
      check("rst_err", 32'(err_a), 0);
      check("rst_first", 32'(first_a), 0);
      reset = 1'b1;

      // 1: clean pass
      start_pass_a();
      check("t1_busy", 32'(busy_a), 1);
      wait_done_a(lat);
      check("t1_latency", 32'(lat), 32'(PASS_CYC));
      check("t1_pass", 32'(pass_a), 1);
      check("t1_err", 32'(err_a), 0);
      check("t1_first", 32'(first_a), 0);
      check("t1_handshakes", 32'(hs_a), 64);
      check("t1_busy_end", 32'(busy_a), 0);
      @(negedge clk);
      check("t1_done_pulse", 32'(done_a), 0);

      // 2: corrupted bytes at 5 and 40
      mem_a[5]  = mem_a[5] ^ 8'h5A;
      mem_a[40] = mem_a[40] ^ 8'h5A;
      start_pass_a();
      wait_done_a(lat);
      check("t2_latency", 32'(lat), 32'(PASS_CYC));
      check("t2_pass", 32'(pass_a), 0);
      check("t2_err", 32'(err_a), 2);
      check("t2_first", 32'(first_a), 5);

      // 3: expected stream stalls 20 cycles at address 10
      start_pass_a();
      wait_addr_a(10, 1'b1, ok);
      check("t3_reach_sample", 32'(ok), 1);
      bus_a.exp_valid = 1'b0;
      stall_ok = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (bus_a.ee_oe_n !== 1'b0 || int'(bus_a.ee_addr) != 10 || bus_a.exp_ready !== 1'b1)
            stall_ok = 1'b0;
      end
      check("t3_stall_hold", 32'(stall_ok), 1);
      bus_a.exp_valid = 1'b1;
      wait_done_a(lat);
      check("t3_latency", 32'(lat), 32'(PASS_CYC + 20));
      check("t3_pass", 32'(pass_a), 0);
      check("t3_err", 32'(err_a), 2);
      check("t3_first", 32'(first_a), 5);
      check("t3_handshakes", 32'(hs_a), 64);

      // 4: every byte wrong, 2-bit counter saturates
      @(negedge clk) hs_clr = 1'b1;
      @(negedge clk) hs_clr = 1'b0;
      start_b = 1'b1;
      @(negedge clk) start_b = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if (done_b) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("t4_done_seen", 32'(ok), 1);
      check("t4_err_sat", 32'(err_b), 3);
      check("t4_first", 32'(first_b), 0);
      check("t4_pass", 32'(pass_b), 0);
      check("t4_handshakes", 32'(hs_b), 64);

      // 5: reset at address 30 (mismatch at 5 already counted), then clean pass
      mem_a[40] = expmem[40];
      start_pass_a();
      wait_addr_a(30, 1'b0, ok);
      check("t5_reach_30", 32'(ok), 1);
      check("t5_err_before", 32'(err_a), 1);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("t5_addr", 32'(bus_a.ee_addr), 0);
      check("t5_oe_n", 32'(bus_a.ee_oe_n), 1);
      check("t5_ready", 32'(bus_a.exp_ready), 0);
      check("t5_busy", 32'(busy_a), 0);
      check("t5_err", 32'(err_a), 0);
      check("t5_first", 32'(first_a), 0);
      no_done = 1'b1;
      repeat (800) begin
         @(negedge clk);
         if (done_a !== 1'b0) no_done = 1'b0;
      end
      check("t5_no_done", 32'(no_done), 1);
      mem_a[5] = expmem[5];
      start_pass_a();
      wait_done_a(lat);
      check("t5_latency", 32'(lat), 32'(PASS_CYC));
      check("t5_pass", 32'(pass_a), 1);
      check("t5_err_end", 32'(err_a), 0);

      // 6: start pulsed while busy is ignored
      start_pass_a();
      wait_addr_a(20, 1'b0, ok);
      check("t6_reach_20", 32'(ok), 1);
      start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
      wait_done_a(lat);
      check("t6_latency", 32'(lat), 32'(PASS_CYC));
      check("t6_pass", 32'(pass_a), 1);
      check("t6_handshakes", 32'(hs_a), 64);
      repeat (3) @(negedge clk);
      check("t6_done_count", 32'(done_cnt_a), 1);
      check("t6_idle", 32'(busy_a), 0);
`ifdef EEPROM_VERIFY_DUMP_EN
      check("t6_dump_count", 32'(dump_cnt), 64);
      check("t6_dump_bad", 32'(dump_bad), 0);
`endif
      check("max_addr", 32'(max_addr_a), 63);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
